// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter for the single write port of the 160x120 video memory, with a
// built-in clear-screen sweep that fills every address with one colour.
module vga_write_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int COLOUR_BITS = 3,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [8*NUM_REQ-1:0]           req_x,
  input  logic [7*NUM_REQ-1:0]           req_y,
  input  logic [COLOUR_BITS*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           clear_start,
  input  logic [COLOUR_BITS-1:0]         clear_colour,
  output logic                           clear_busy,
  output logic                           clear_done,
  output logic                           oob_drop,
  output logic [14:0]                    mem_address,
  output logic [COLOUR_BITS-1:0]         mem_data,
  output logic                           mem_wren
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state_reg;
  logic [PTR_W-1:0]       ptr_reg;
  logic [14:0]            sweep_reg;
  logic [COLOUR_BITS-1:0] fill_reg;

  // A requester just acked is masked so it cannot win again before it updates req.
  logic [NUM_REQ-1:0] eligible;
  assign eligible = req & ~ack;

  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  int               idx;

  // Scan from the farthest offset down so the nearest eligible index at/after the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  logic [7:0]             sel_x;
  logic [6:0]             sel_y;
  logic [COLOUR_BITS-1:0] sel_colour;
  logic                   on_screen;
  logic [14:0]            sel_addr;
  logic [PTR_W-1:0]       ptr_next;

  assign sel_x      = req_x[8*int'(grant_idx) +: 8];
  assign sel_y      = req_y[7*int'(grant_idx) +: 7];
  assign sel_colour = req_colour[COLOUR_BITS*int'(grant_idx) +: COLOUR_BITS];
  assign on_screen  = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);
  // y*160 as two shifts: y*128 + y*32.
  assign sel_addr   = 15'({sel_y, 7'b0}) + 15'({sel_y, 5'b0}) + 15'(sel_x);
  assign ptr_next   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      sweep_reg   <= '0;
      fill_reg    <= '0;
      ack         <= '0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      oob_drop    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      ack        <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      oob_drop   <= 1'b0;
      mem_wren   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clear_start) begin
            fill_reg  <= clear_colour;
            sweep_reg <= '0;
            state_reg <= CLEAR;
          end else if (grant_valid) begin
            ack     <= NUM_REQ'(1) << grant_idx;
            ptr_reg <= ptr_next;
            if (on_screen) begin
              mem_wren    <= 1'b1;
              mem_address <= sel_addr;
              mem_data    <= sel_colour;
            end else begin
              oob_drop <= 1'b1;
            end
          end
        end
        CLEAR: begin
          mem_wren    <= 1'b1;
          clear_busy  <= 1'b1;
          mem_address <= sweep_reg;
          mem_data    <= fill_reg;
          sweep_reg   <= sweep_reg + 15'd1;
          if (sweep_reg == LAST_ADDR) begin
            clear_done <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: grants, address translation, off-screen drops,
// clear sweep and reset during a sweep.
module tb_vga_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  ack;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_busy;
  logic        clear_done;
  logic        oob_drop;
  logic [14:0] mem_address;
  logic [2:0]  mem_data;
  logic        mem_wren;

  int checks = 0;
  int failures = 0;

  vga_write_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_colour   (req_colour),
    .ack          (ack),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .oob_drop     (oob_drop),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic set_req(input int i, input int x, input int y, input int c);
    req_x[8*i +: 8]      = 8'(x);
    req_y[7*i +: 7]      = 7'(y);
    req_colour[3*i +: 3] = 3'(c);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_wren"}, 32'(mem_wren), 0);
    check({tag, "_addr"}, 32'(mem_address), 0);
    check({tag, "_data"}, 32'(mem_data), 0);
    check({tag, "_busy"}, 32'(clear_busy), 0);
    check({tag, "_done"}, 32'(clear_done), 0);
    check({tag, "_oob"}, 32'(oob_drop), 0);
  endtask

  // Grant order and addresses for three held requesters starting from pointer 0.
  logic [2:0]  exp_ack_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [14:0] exp_addr_seq[3] = '{15'd1, 15'd2, 15'd3};

  initial begin
    int  first_bad;
    bit  ok;

    // Reset
    tick();
    check_reset_values("reset");
    reset = 1'b0;

    // 1: single pixel (5,2) -> 2*160+5 = 325
    set_req(0, 5, 2, 3'b101);
    req = 3'b001;
    tick();
    check("t1_ack", 32'(ack), 3'b001);
    check("t1_wren", 32'(mem_wren), 1);
    check("t1_addr", 32'(mem_address), 325);
    check("t1_data", 32'(mem_data), 3'b101);
    req = 3'b000;
    tick();
    check("t1_wren_after", 32'(mem_wren), 0);
    check("t1_ack_after", 32'(ack), 0);

    // 2: all three held, pointer back at 0 after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1, 0, 3'b001);
    set_req(1, 2, 0, 3'b010);
    set_req(2, 3, 0, 3'b100);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t2_ack%0d", k), 32'(ack), 32'(exp_ack_seq[k]));
      check($sformatf("t2_wren%0d", k), 32'(mem_wren), 1);
      check($sformatf("t2_addr%0d", k), 32'(mem_address), 32'(exp_addr_seq[k % 3]));
    end
    req = 3'b000;
    tick();
    check("t2_idle_wren", 32'(mem_wren), 0);

    // 3: off-screen drops from requester 1 (pointer now 0)
    set_req(1, 160, 0, 3'b111);
    req = 3'b010;
    tick();
    check("t3a_ack", 32'(ack), 3'b010);
    check("t3a_oob", 32'(oob_drop), 1);
    check("t3a_wren", 32'(mem_wren), 0);
    req = 3'b000;
    tick();
    check("t3a_oob_after", 32'(oob_drop), 0);
    set_req(1, 0, 120, 3'b111);
    req = 3'b010;
    tick();
    check("t3b_ack", 32'(ack), 3'b010);
    check("t3b_oob", 32'(oob_drop), 1);
    check("t3b_wren", 32'(mem_wren), 0);
    req = 3'b000;
    tick();
    check("t3b_oob_after", 32'(oob_drop), 0);

    // 4: corner and row-start addresses
    set_req(0, 159, 119, 3'b011);
    req = 3'b001;
    tick();
    check("t4a_ack", 32'(ack), 3'b001);
    check("t4a_addr", 32'(mem_address), 19199);
    check("t4a_wren", 32'(mem_wren), 1);
    req = 3'b000;
    tick();
    set_req(1, 0, 1, 3'b110);
    req = 3'b010;
    tick();
    check("t4b_addr", 32'(mem_address), 160);
    check("t4b_data", 32'(mem_data), 3'b110);
    req = 3'b000;
    tick();
    // Pointer is now 2.

    // 5: clear with black while req=011 is held; a second clear_start mid-sweep is ignored
    set_req(0, 7, 3, 3'b001);
    set_req(1, 8, 3, 3'b010);
    req = 3'b011;
    clear_colour = 3'b000;
    clear_start = 1'b1;
    tick();
    check("t5_start_ack", 32'(ack), 0);
    check("t5_start_wren", 32'(mem_wren), 0);
    clear_start = 1'b0;
    clear_colour = 3'b111;
    ok = 1'b1;
    first_bad = -1;
    for (int i = 0; i < 19200; i++) begin
      clear_start = (i == 5000);
      tick();
      if (!(clear_busy === 1'b1 && mem_wren === 1'b1 && mem_address === 15'(i) &&
            mem_data === 3'b000 && ack === 3'b000 && clear_done === (i == 19199))) begin
        if (ok) first_bad = i;
        ok = 1'b0;
      end
    end
    clear_start = 1'b0;
    check("t5_sweep_first_bad_index", 32'(first_bad), 32'(-1));
    check("t5_done_at_last", 32'(clear_done), 1);
    tick();
    check("t5_busy_dropped", 32'(clear_busy), 0);
    check("t5_done_dropped", 32'(clear_done), 0);
    check("t5_post_ack", 32'(ack), 3'b001);
    check("t5_post_addr", 32'(mem_address), 487);
    check("t5_post_data", 32'(mem_data), 3'b001);
    req = 3'b000;
    tick();

    // 6: reset at sweep address 5000
    clear_colour = 3'b101;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i <= 5000; i++) tick();
    check("t6_addr_before_reset", 32'(mem_address), 5000);
    check("t6_busy_before_reset", 32'(clear_busy), 1);
    reset = 1'b1;
    tick();
    check_reset_values("t6_reset");
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_wren !== 1'b0 || clear_busy !== 1'b0) ok = 1'b0;
    end
    check("t6_stays_idle", 32'(ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
